// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings and decoded-control bundle shared by the MIPS pipeline.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [4:0] REG_RA   = 5'd31;
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic branch;
    logic jump;
    logic reg_dst;
    logic illegal;
  } ctrl_t;
endpackage

// File: rtl/id_decode_stage_reg_file.sv
// reg_file: 32x32 register file, two async read ports, one write port, optional writeback bypass.
module reg_file #(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [32];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  function automatic logic [31:0] rd(input logic [4:0] a);
    return a == 5'd0 ? 32'd0 : (WB_BYPASS && we && a == wa) ? wd : regs[a];
  endfunction
  assign rd1 = rd(ra1);
  assign rd2 = rd(ra2);
endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: IF/ID register, register file, control decode and immediate extension.
module id_decode_stage
  import mips_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] instruction_in,
  input  logic [31:0] PCPlus4_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        RegWriteW,
  input  logic [4:0]  wb_addr_W,
  input  logic [31:0] wb_data_W,
  output logic [31:0] PCPlus4_out,
  output logic [31:0] imm_signExtended_out,
  output logic [31:0] imm_zeroExtended_out,
  output logic [4:0]  rt_addr_out,
  output logic [4:0]  rd_addr_out,
  output logic [4:0]  shamt_out,
  output logic [25:0] address_Jtype_out,
  output logic [31:0] rs_reg_out,
  output logic [31:0] rt_reg_out,
  output logic        RegWriteD,
  output logic        MemtoRegD,
  output logic        MemWriteD,
  output logic        BranchD,
  output logic        JumpD,
  output logic        RegDstD,
  output logic [5:0]  ALUopD,
  output logic [5:0]  ALUfunctD,
  output logic        illegal_instr
);
  logic [31:0] instr, pc4;
  logic        valid, r_alu;
  logic [5:0]  op, funct;
  ctrl_t       ctrl;
  always_ff @(posedge CLK)
    if (RESET) begin
      instr <= '0;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= '0;
      valid <= 1'b0;
    end else if (!stall) begin
      instr <= instruction_in;
      pc4   <= PCPlus4_in;
      valid <= 1'b1;
    end
  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign r_alu = funct inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_NOR, FN_OR, FN_XOR,
                               FN_SLL, FN_SLLV, FN_SRL, FN_SRLV, FN_SRA, FN_SRAV, FN_SLT};
  // An unrecognised encoding leaves every control low so it travels on as a bubble.
  always_comb begin
    ctrl = '0;
    if (valid)
      case (op)
        OP_RTYPE: begin
          ctrl.reg_write = r_alu;
          ctrl.reg_dst   = r_alu;
          ctrl.jump      = funct == FN_JR;
          ctrl.illegal   = !r_alu && funct != FN_JR;
        end
        OP_LW: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        OP_SW:                                   ctrl.mem_write = 1'b1;
        OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: ctrl.reg_write = 1'b1;
        OP_BEQ, OP_BNE:                          ctrl.branch = 1'b1;
        OP_J:                                    ctrl.jump = 1'b1;
        OP_JAL: begin
          ctrl.jump      = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        default:                                 ctrl.illegal = 1'b1;
      endcase
  end
  assign {RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD, illegal_instr} = ctrl;
  assign PCPlus4_out          = pc4;
  assign imm_signExtended_out = {{16{instr[15]}}, instr[15:0]};
  assign imm_zeroExtended_out = {16'b0, instr[15:0]};
  assign rt_addr_out          = instr[20:16];
  assign rd_addr_out          = instr[15:11];
  assign shamt_out            = instr[10:6];
  assign address_Jtype_out    = instr[25:0];
  assign ALUopD               = op;
  assign ALUfunctD            = funct;
  reg_file #(.WB_BYPASS(WB_BYPASS)) u_rf (
    .clk(CLK),
    .rst(RESET),
    .ra1(instr[25:21]),
    .ra2(instr[20:16]),
    .rd1(rs_reg_out),
    .rd2(rt_reg_out),
    .we(RegWriteW),
    .wa(wb_addr_W),
    .wd(wb_data_W)
  );
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: scoreboard bench driving a bypassing and a non-bypassing decode stage in lockstep.
module tb_id_decode_stage;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic        RESET = 1'b1, stall = 1'b0, flush = 1'b0, RegWriteW = 1'b0;
  logic [31:0] instruction_in = '0, PCPlus4_in = '0, wb_data_W = '0;
  logic [4:0]  wb_addr_W = '0;
  logic [31:0] b_pc, b_ims, b_imz, b_rs, b_rt, n_pc, n_ims, n_imz, n_rs, n_rt;
  logic [4:0]  b_rta, b_rda, b_sh, n_rta, n_rda, n_sh;
  logic [25:0] b_aj, n_aj;
  logic [5:0]  b_op, b_fn, n_op, n_fn;
  logic        b_rw, b_m2r, b_mw, b_br, b_j, b_rd, b_ill;
  logic        n_rw, n_m2r, n_mw, n_br, n_j, n_rd, n_ill;
  id_decode_stage #(.WB_BYPASS(1'b1)) u_byp (
    .CLK(CLK), .RESET(RESET), .instruction_in(instruction_in), .PCPlus4_in(PCPlus4_in),
    .stall(stall), .flush(flush), .RegWriteW(RegWriteW), .wb_addr_W(wb_addr_W), .wb_data_W(wb_data_W),
    .PCPlus4_out(b_pc), .imm_signExtended_out(b_ims), .imm_zeroExtended_out(b_imz),
    .rt_addr_out(b_rta), .rd_addr_out(b_rda), .shamt_out(b_sh), .address_Jtype_out(b_aj),
    .rs_reg_out(b_rs), .rt_reg_out(b_rt), .RegWriteD(b_rw), .MemtoRegD(b_m2r), .MemWriteD(b_mw),
    .BranchD(b_br), .JumpD(b_j), .RegDstD(b_rd), .ALUopD(b_op), .ALUfunctD(b_fn), .illegal_instr(b_ill)
  );
  id_decode_stage #(.WB_BYPASS(1'b0)) u_nob (
    .CLK(CLK), .RESET(RESET), .instruction_in(instruction_in), .PCPlus4_in(PCPlus4_in),
    .stall(stall), .flush(flush), .RegWriteW(RegWriteW), .wb_addr_W(wb_addr_W), .wb_data_W(wb_data_W),
    .PCPlus4_out(n_pc), .imm_signExtended_out(n_ims), .imm_zeroExtended_out(n_imz),
    .rt_addr_out(n_rta), .rd_addr_out(n_rda), .shamt_out(n_sh), .address_Jtype_out(n_aj),
    .rs_reg_out(n_rs), .rt_reg_out(n_rt), .RegWriteD(n_rw), .MemtoRegD(n_m2r), .MemWriteD(n_mw),
    .BranchD(n_br), .JumpD(n_j), .RegDstD(n_rd), .ALUopD(n_op), .ALUfunctD(n_fn), .illegal_instr(n_ill)
  );
  typedef struct {
    logic [6:0]   ctrl;
    logic [116:0] fields;
    logic [31:0]  pc;
    logic         pc_chk;
    logic [31:0]  rs1, rt1, rs0, rt0;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, issued = 0, popped = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_instr, m_pc;
  logic        m_valid, m_pc_known;
  // {RegWrite, MemtoReg, MemWrite, Branch, Jump, RegDst, illegal} from the MIPS instruction table.
  function automatic logic [6:0] ref_ctrl(input logic v, input logic [31:0] i);
    if (!v) return 7'b0;
    case (i[31:26])
      6'd0: case (i[5:0])
        6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd39, 6'd37, 6'd38,
        6'd0, 6'd4, 6'd2, 6'd6, 6'd3, 6'd7, 6'd42: return 7'b1000010;
        6'd8:    return 7'b0000100;
        default: return 7'b0000001;
      endcase
      6'd35:                         return 7'b1100000;
      6'd43:                         return 7'b0010000;
      6'd8, 6'd9, 6'd12, 6'd13, 6'd14: return 7'b1000000;
      6'd4, 6'd5:                    return 7'b0001000;
      6'd2:                          return 7'b0000100;
      6'd3:                          return 7'b1000100;
      default:                       return 7'b0000001;
    endcase
  endfunction
  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic byp);
    if (a == 0) return 32'd0;
    if (byp && RegWriteW && a == wb_addr_W) return wb_data_W;
    return m_regs[a];
  endfunction
  task automatic model_edge();
    if (RESET) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_instr = '0; m_pc = '0; m_valid = 1'b0; m_pc_known = 1'b1;
    end else begin
      if (RegWriteW && wb_addr_W != 0) m_regs[wb_addr_W] = wb_data_W;
      if (flush) begin
        m_instr = '0; m_valid = 1'b0; m_pc_known = 1'b0;
      end else if (!stall) begin
        m_instr = instruction_in; m_pc = PCPlus4_in; m_valid = 1'b1; m_pc_known = 1'b1;
      end
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic f, input logic [31:0] ins,
                     input logic [31:0] pc, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    @(posedge CLK);
    model_edge();
    #1;
    RESET = r; stall = s; flush = f; instruction_in = ins; PCPlus4_in = pc;
    RegWriteW = we; wb_addr_W = wa; wb_data_W = wd;
    e.ctrl   = ref_ctrl(m_valid, m_instr);
    e.fields = {{{16{m_instr[15]}}, m_instr[15:0]}, {16'b0, m_instr[15:0]}, m_instr[20:16],
                m_instr[15:11], m_instr[10:6], m_instr[25:0], m_instr[31:26], m_instr[5:0]};
    e.pc     = m_pc;
    e.pc_chk = m_pc_known;
    e.rs1 = ref_read(m_instr[25:21], 1'b1);
    e.rt1 = ref_read(m_instr[20:16], 1'b1);
    e.rs0 = ref_read(m_instr[25:21], 1'b0);
    e.rt0 = ref_read(m_instr[20:16], 1'b0);
    q.push_back(e);
    issued++;
  endtask
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask
  always @(negedge CLK)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      popped++;
      chk("ctrl_byp", {b_rw, b_m2r, b_mw, b_br, b_j, b_rd, b_ill}, e.ctrl);
      chk("ctrl_nob", {n_rw, n_m2r, n_mw, n_br, n_j, n_rd, n_ill}, e.ctrl);
      chk("fields_byp", {b_ims, b_imz, b_rta, b_rda, b_sh, b_aj, b_op, b_fn}, e.fields);
      chk("fields_nob", {n_ims, n_imz, n_rta, n_rda, n_sh, n_aj, n_op, n_fn}, e.fields);
      if (e.pc_chk) chk("pc4", {b_pc, n_pc}, {e.pc, e.pc});
      chk("rs_byp", b_rs, e.rs1);
      chk("rt_byp", b_rt, e.rt1);
      chk("rs_nob", n_rs, e.rs0);
      chk("rt_nob", n_rt, e.rt0);
    end
  localparam logic [5:0] OPS [13] = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd9, 6'd12, 6'd13, 6'd14,
                                       6'd4, 6'd5, 6'd2, 6'd3, 6'd63};
  localparam logic [5:0] FNS [16] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
                                       6'd42, 6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8};
  initial begin
    logic [31:0] ins;
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    cyc(0, 0, 0, 32'h8D28FFFC, 32'h104, 0, 0, 0);
    cyc(0, 0, 0, 32'h01205020, 32'h108, 0, 0, 0);
    cyc(0, 0, 0, 32'h00000820, 32'h10C, 1, 5'd9, 32'h12345678);
    cyc(0, 0, 0, 32'h00000820, 32'h110, 1, 5'd0, 32'hFFFFFFFF);
    cyc(0, 0, 0, 32'h1109FFFE, 32'h114, 1, 5'd0, 32'hFFFFFFFF);
    cyc(0, 1, 0, 32'h8D28FFFC, 32'h118, 1, 5'd8, 32'hA5A5A5A5);
    cyc(0, 1, 0, 32'h8D28FFFC, 32'h118, 0, 0, 0);
    cyc(0, 1, 1, 32'h8D28FFFC, 32'h118, 0, 0, 0);
    cyc(0, 0, 0, 32'h03E00008, 32'h11C, 0, 0, 0);
    cyc(0, 0, 0, 32'h0C000040, 32'h120, 1, 5'd31, 32'h00000124);
    cyc(0, 0, 0, 32'hFC000000, 32'h124, 1, 5'd5, 32'hCAFEF00D);
    cyc(0, 0, 0, 32'h00A50820, 32'h128, 0, 0, 0);
    cyc(1, 0, 0, 32'h00A50820, 32'h12C, 0, 0, 0);
    cyc(0, 0, 0, 32'h00A50820, 32'h130, 0, 0, 0);
    cyc(0, 0, 0, 32'h0, 32'h134, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      ins[31:26] = OPS[$urandom_range(0, 12)];
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      if (ins[31:26] == 6'd0 && $urandom_range(0, 7) != 0) ins[5:0] = FNS[$urandom_range(0, 15)];
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, ins,
          $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    @(posedge CLK);
    chk("queue_drained", 128'(q.size()), 128'd0);
    chk("issued_vs_popped", 128'(popped), 128'(issued));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Instruction-decode stage of the five-stage MIPS pipeline; it produces every signal the execute stage latches into its ID/EX register. It holds the IF/ID pipeline register, the 32×32 register file written by writeback, the main control decoder and the immediate extenders. Stall and flush inputs from the hazard unit let it hold an instruction or turn it into a bubble.

## Interface
- `WB_BYPASS`, default 1: when 1, a register read that hits the register being written in the same cycle returns `wb_data_W`; when 0, it returns the old contents.
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `instruction_in` in 32: instruction from the fetch stage.
- `PCPlus4_in` in 32: PC+4 from the fetch stage.
- `stall` in 1: hold the IF/ID register.
- `flush` in 1: load a bubble into IF/ID.
- `RegWriteW` in 1: writeback write enable.
- `wb_addr_W` in 5: writeback destination register.
- `wb_data_W` in 32: writeback data.
- `PCPlus4_out` out 32: latched PC+4.
- `imm_signExtended_out` out 32: `{{16{instr[15]}}, instr[15:0]}`.
- `imm_zeroExtended_out` out 32: `{16'b0, instr[15:0]}`.
- `rt_addr_out` out 5: `instr[20:16]`.
- `rd_addr_out` out 5: `instr[15:11]`.
- `shamt_out` out 5: `instr[10:6]`.
- `address_Jtype_out` out 26: `instr[25:0]`.
- `rs_reg_out` out 32: register-file read of `instr[25:21]`.
- `rt_reg_out` out 32: register-file read of `instr[20:16]`.
- `RegWriteD`, `MemtoRegD`, `MemWriteD`, `BranchD`, `JumpD`, `RegDstD` out 1: decoded controls.
- `ALUopD` out 6: `instr[31:26]`.
- `ALUfunctD` out 6: `instr[5:0]`.
- `illegal_instr` out 1: the valid instruction is unrecognized.

## Operation
- **IF/ID register.** Holds `instr`, `pc4` and `valid`.
  - Each edge, in priority order: `RESET` loads instr=0, pc4=0, valid=0; else `flush` loads instr=0, valid=0 (pc4 don't-care); else `stall` holds all three; else loads the inputs with valid=1.
  - Flush beats stall when both are asserted.
- **Decode.** Combinational from the registered instruction.
  - Field outputs are always driven, even when valid=0.
  - When valid=0, all six controls and `illegal_instr` are 0.
- **Controls** for a valid instruction:
  - RegWriteD=1 for R-type (op 000000) with funct in {add, addu, sub, subu, and, nor, or, xor, sll, sllv, srl, srlv, sra, srav, slt}, and for lw, addi, addiu, andi, ori, xori, jal.
  - RegDstD=1 for R-type only.
  - MemtoRegD=1 for lw only. MemWriteD=1 for sw only.
  - BranchD=1 for beq and bne.
  - JumpD=1 for j, jal, and R-type jr (funct 001000). jr has RegWriteD=0.
  - Any other op/funct: illegal_instr=1 and all controls 0, so it becomes a bubble.
- **Register file.** 32×32 bits.
  - Register 0 reads 0 always; writes to it are discarded.
  - Write on the rising edge when RegWriteW=1 and RESET=0.
  - Writes proceed regardless of stall or flush.
  - RESET clears all 32 registers.
- **Reads.** Two asynchronous read ports. When `WB_BYPASS`=1 and RegWriteW=1, a read whose address equals `wb_addr_W` (nonzero) returns `wb_data_W`.

## Timing
- Latency: an instruction presented before edge N produces valid decode outputs after edge N. The execute stage captures them at edge N+1.
- All outputs are combinational from the IF/ID and register-file state; there are no output registers.
- Reset values, after the RESET edge:
  - All controls and `illegal_instr` are 0.
  - `PCPlus4_out` is 0; all field outputs are 0.
  - `rs_reg_out` and `rt_reg_out` are 0.
- RESET in mid-stream discards the in-flight instruction and all register contents in the same edge.
- The stall input causes no loss: the held instruction's outputs are stable. Register reads still reflect writebacks that occur during the stall.

## Structure
- Shared package `mips_pkg`:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_BEQ, OP_BNE, OP_J, OP_JAL;
  - funct constants: FN_ADD … FN_JR;
  - REG_RA = 5'd31.
- One sub-module, `reg_file`: 2 read ports, 1 write port, synchronous reset, `WB_BYPASS` passed through.
- Control decode stays inline as one combinational block.

## Test plan
- **Reset and lw decode.** RESET one cycle, then lw $8,-4($9) (0x8D28FFFC). Expected after the next edge:
  - RegWriteD=1, MemtoRegD=1, RegDstD=0;
  - imm_signExtended_out=0xFFFFFFFC, imm_zeroExtended_out=0x0000FFFC, rt_addr_out=8.
- **Writeback and bypass.** Write 0x12345678 to $9 via writeback in the same cycle that add $10,$9,$0 sits in IF/ID. Expected: rs_reg_out=0x12345678 in that cycle with WB_BYPASS=1, and the old value with WB_BYPASS=0.
- **$0 hardwired.** Write 0xFFFFFFFF to $0. Expected: a subsequent read of $0 returns 0.
- **Stall and flush.**
  - Stall for 2 cycles with a new instruction at the input: outputs stay those of the held instruction.
  - Flush and stall together: next edge gives all controls 0 and valid=0.
- **Jumps and branches.**
  - jr $31: JumpD=1, RegWriteD=0.
  - jal 0x0000040: JumpD=1, RegWriteD=1, address_Jtype_out=0x40.
  - beq: BranchD=1 only.
- **Illegal and mid-stream reset.**
  - Opcode 111111: illegal_instr=1, all controls 0.
  - RESET asserted with registers loaded: all reads return 0 on the next cycle.
